// File: rtl/uart_tx_queue_if.sv
// Byte-producer side of uart_tx_queue: push handshake plus transmitter status.
//
// Handshake: a byte transfers on every rising clk edge where in_valid and
// in_ready are both high. in_ready is combinational (occupancy < depth) and
// does not depend on in_valid; the producer may hold in_valid high
// indefinitely and must keep in_data stable while in_valid is high and
// in_ready is low.
interface uart_tx_queue_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    // Producer / testbench side
    modport master (
        output in_data, in_valid,
        input  in_ready, uart_tx, busy, fifo_count
    );

    // Transmitter side
    modport slave (
        input  in_data, in_valid,
        output in_ready, uart_tx, busy, fifo_count
    );
endinterface

// File: rtl/uart_tx_queue.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first,
// DELAY_FRAMES clocks per bit, queued frames sent back-to-back.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_queue #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_queue_if.slave  bus,
    output logic [2:0]      dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(DELAY_FRAMES);
    localparam logic [TW-1:0] TICK_LAST = TW'(DELAY_FRAMES - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          tx_q;
    logic          busy_q;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    logic       push;
    logic       pop;
    logic       next_idle;
    logic       tick_end;
    logic [7:0] pop_data;

    assign bus.in_ready   = (count_q < DEPTH_C);
    assign bus.uart_tx    = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_count = count_q;
    assign dbg_state_o    = state_q;

    assign push     = bus.in_valid && bus.in_ready;
    assign tick_end = (tick_q == TICK_LAST);
    // A pop at the end of a stop bit may take a byte pushed on that same edge
    // into an empty FIFO; it is not in storage yet, so bypass it.
    assign pop_data = (count_q == '0) ? bus.in_data : mem_q[rd_ptr_q];

    // Pop decision, whether the FSM lands in IDLE, and next occupancy.
    always_comb begin
        pop       = 1'b0;
        next_idle = 1'b0;
        count_d   = count_q;
        if (state_q == S_IDLE) begin
            pop       = (count_q != '0);
            next_idle = !pop;
        end else if (state_q == S_STOP && tick_end) begin
            pop       = (count_q != '0) || push;
            next_idle = !pop;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Pointers, occupancy and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            busy_q  <= !next_idle || (count_d != '0);
        end
    end

    // Frame FSM with registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        sh_q    <= pop_data;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^pop_data;
`endif
                        tick_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick_end) begin
                        tick_q  <= '0;
                        tx_q    <= sh_q[0];
                        state_q <= S_DATA;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_end) begin
                        tick_q <= '0;
                        sh_q   <= sh_q >> 1;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q <= sh_q[1];
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick_end) begin
                        tick_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick_end) begin
                        tick_q <= '0;
                        if (pop) begin
                            sh_q    <= pop_data;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^pop_data;
`endif
                            bit_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue at DELAY_FRAMES=4, FIFO_DEPTH=16.
module tb_uart_tx_queue;
    localparam int D     = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = D * NB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       rx_par;

    uart_tx_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_queue #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
`ifdef UART_TX_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b0, 1'b1, b, 1'b0};
`endif
        return f;
    endfunction

    // Line decoder: samples mid-bit on the falling clock edge.
    initial begin : decoder
        bit rx_busy;
        int rx_cnt;
        int rx_k;
        logic [7:0] rx_sh;
        rx_busy = 0;
        rx_cnt  = 0;
        rx_k    = 0;
        rx_sh   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_busy = 0;
            end else if (!rx_busy) begin
                if (bus.uart_tx === 1'b0) begin
                    rx_busy = 1;
                    rx_cnt  = 0;
                    rx_k    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == (D + D / 2 - 1) + D * rx_k) begin
                    if (rx_k < 8) begin
                        rx_sh[rx_k] = bus.uart_tx;
                    end else if (rx_k == NB - 2) begin
                        chk("stop_bit", {31'b0, bus.uart_tx}, 32'd1);
                        rx_q.push_back(rx_sh);
                        rx_busy = 0;
                    end else begin
                        rx_par = bus.uart_tx;
                    end
                    rx_k++;
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, bus.busy}, 32'd0);
    endtask

    // Scoreboard drain: every expected byte must have been decoded, in order.
    task automatic wait_rx(input string tag, input int budget);
        int n;
        logic [7:0] e;
        logic [7:0] r;
        n = 0;
        while (rx_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            chk(tag, {24'b0, r}, {24'b0, e});
        end
        rx_q.delete();
    endtask

    initial begin : main
        logic [10:0] f;
        int n;
        int t0;
        int sent;
        bit rdy;
        bit v;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart_tx", {31'b0, bus.uart_tx}, 32'd1);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_fifo_count", {27'b0, bus.fifo_count}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Single byte 0x55, checked clock by clock
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("sb_count_after_push", {27'b0, bus.fifo_count}, 32'd1);
        chk("sb_line_before_start", {31'b0, bus.uart_tx}, 32'd1);
        chk("sb_busy_after_push", {31'b0, bus.busy}, 32'd1);
        f = frame_bits(8'h55);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            chk("sb_line", {31'b0, bus.uart_tx}, {31'b0, f[c / D]});
            if (c == 0) chk("sb_count_after_pop", {27'b0, bus.fifo_count}, 32'd0);
        end
        chk("sb_busy_last_stop_clk", {31'b0, bus.busy}, 32'd1);
        tick();
        chk("sb_busy_fall", {31'b0, bus.busy}, 32'd0);
        chk("sb_line_idle", {31'b0, bus.uart_tx}, 32'd1);
        exp_q.push_back(8'h55);
        wait_rx("sb_byte", 200);

        // Back-to-back frames
        wait_idle("b2b_idle", 500);
        start_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        tick();
        t0 = cyc;
        bus.in_data = 8'h42;
        tick();
        bus.in_data = 8'h43;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        chk("b2b_total_len", cyc - t0, 3 * FRAME + 1);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        wait_rx("b2b_byte", 500);
        chk("b2b_nstarts", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("b2b_gap01", start_q[1] - start_q[0], FRAME);
            chk("b2b_gap12", start_q[2] - start_q[1], FRAME);
        end

        // Full FIFO with in_valid held high
        wait_idle("full_idle", 500);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h80;
        n = 0;
        for (int i = 0; i < 100 && bus.fifo_count != 5'd16; i++) begin
            rdy = bus.in_ready;
            tick();
            if (rdy) n++;
            bus.in_data = bus.in_ready ? 8'(8'h80 + n) : 8'hEE;
        end
        chk("full_accepted", n, 17);
        chk("full_count", {27'b0, bus.fifo_count}, 32'd16);
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (n == 5) chk("full_hold_count", {27'b0, bus.fifo_count}, 32'd16);
        end
        bus.in_valid = 1'b0;
        chk("full_ready_return", n, FRAME + 1 - 16);
        chk("full_count_after_pop", {27'b0, bus.fifo_count}, 32'd15);
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h80 + i));
        wait_rx("full_byte", 17 * FRAME + 200);

        // Wrap-around: 40 incrementing bytes, random in_valid
        wait_idle("wrap_idle", 500);
        sent = 0;
        for (int i = 0; i < 5000 && sent < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = 8'(sent);
            rdy = bus.in_ready;
            tick();
            if (v && rdy) sent++;
        end
        bus.in_valid = 1'b0;
        chk("wrap_sent", sent, 40);
        for (int i = 0; i < 40; i++) exp_q.push_back(8'(i));
        wait_rx("wrap_byte", 40 * FRAME + 200);

        // Reset mid-frame (DATA bit 3 of 0x11, four more bytes queued)
        wait_idle("mrst_idle", 2000);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'(8'h11 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (14) tick();
        chk("mrst_line_bit3", {31'b0, bus.uart_tx}, 32'd0);
        chk("mrst_count_before", {27'b0, bus.fifo_count}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_line_async", {31'b0, bus.uart_tx}, 32'd1);
        chk("mrst_count", {27'b0, bus.fifo_count}, 32'd0);
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mrst_state", {29'b0, dbg_state}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("mrst_no_partial", rx_q.size(), 0);
        rx_q.delete();
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_idle("mrst_a5_idle", 500);
        repeat (3 * FRAME) tick();
        exp_q.push_back(8'hA5);
        wait_rx("mrst_a5", 200);

`ifdef UART_TX_PARITY_EN
        // Even parity
        wait_idle("par_idle", 500);
        bus.in_data  = 8'h07;
        bus.in_valid = 1'b1;
        tick();
        t0 = cyc;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        chk("par_frame_len", cyc - t0, 11 * D + 1);
        exp_q.push_back(8'h07);
        wait_rx("par_07", 200);
        chk("par_07_bit", {31'b0, rx_par}, 32'd1);
        bus.in_data  = 8'h03;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_idle("par_03_idle", 500);
        exp_q.push_back(8'h03);
        wait_rx("par_03", 200);
        chk("par_03_bit", {31'b0, rx_par}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered UART transmitter that sits upstream of the board `uart_tx` pin and downstream of any byte producer (RX echo path, CPU debug port, test-message ROM). It accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames, LSB first, at `DELAY_FRAMES` clocks per bit. Frames from queued bytes are sent back-to-back with no idle gap.

## Interface
- `DELAY_FRAMES`, default 234: clocks per bit (27 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries. Power of two, ≥ 2.
- `clk` input 1: single clock; all state on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 8: byte to queue.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: FIFO can accept this cycle. Combinational: `fifo_count < FIFO_DEPTH`.
- `uart_tx` output 1: serial line, registered, idle high.
- `busy` output 1: registered, high while a frame is in flight or the FIFO is non-empty.
- `fifo_count` output `$clog2(FIFO_DEPTH)+1`: current occupancy, registered.

## Operation
- **Push:** occurs at an edge where `in_valid && in_ready`. `in_data` is written at the write pointer.
- **Pop:** performed by the FSM only, as described below.
- **Pointers:** `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
- **Count update:** `fifo_count` is incremented on push and decremented on pop. Simultaneous push and pop leaves it unchanged.
- **Full:** `in_ready` is low, and a push is refused even if a pop occurs on the same edge.
- **Empty:** no pop occurs. A byte pushed at edge N becomes poppable at edge N+1.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - **IDLE:** `uart_tx`=1. If `fifo_count != 0`, pop into shift register `sh`, clear bit counter and tick counter, and go to START.
  - **START:** `uart_tx`=0 for `DELAY_FRAMES` clocks, then go to DATA.
  - **DATA:** `uart_tx`=`sh[0]` for `DELAY_FRAMES` clocks per bit, then shift `sh` right. After bit index 7, go to PARITY (if compiled in) or STOP.
  - **STOP:** `uart_tx`=1 for `DELAY_FRAMES` clocks. On the final clock:
    - if `fifo_count != 0` (count includes a push on that same edge), pop and go directly to START;
    - otherwise go to IDLE.
- **Tick counter:** width `$clog2(DELAY_FRAMES)`. It counts 0 to `DELAY_FRAMES-1`, and a bit ends when the count equals `DELAY_FRAMES-1`. It resets to 0 on every bit boundary.
- **`busy`:** `(state != IDLE) || (fifo_count != 0)`, evaluated on next-state values.
- **Reset values:**
  - `uart_tx`=1, `busy`=0, `fifo_count`=0, so `in_ready`=1.
  - State is IDLE and all pointers and counters are 0.
- **Reset mid-frame:** the line goes high immediately (asynchronous), the partial frame is abandoned, and FIFO contents are discarded.
- **FIFO storage:** needs no reset.

## Timing
- **Latency:** with the FSM in IDLE and the FIFO empty, a byte accepted at edge N drives the start bit from edge N+1.
- **Frame length:** exactly 10·`DELAY_FRAMES` clocks, or 11·`DELAY_FRAMES` with parity.
- **Back-to-back frames:** the next start bit begins on the edge immediately after the last stop-bit clock, with zero idle clocks.
- **`in_ready` vs pop:** `in_ready` reflects occupancy before that edge's pop, so a slot freed by a pop becomes visible one cycle later.
- **Throughput:** the producer may hold `in_valid` high continuously. Accepted bytes are transmitted in order.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (`^data`) for `DELAY_FRAMES` clocks, giving an 8E1 frame of 11 bits.
  - The parity bit is computed when the byte is popped.
- **Not defined:** the PARITY state and its logic are absent, giving an 8N1 frame of 10 bits.

## Test plan
- **Single byte:** `DELAY_FRAMES`=4, push 0x55 at edge N.
  - `uart_tx` is 0 from N+1 for 4 clocks.
  - It then carries 1,0,1,0,1,0,1,0 (4 clocks each), then 1 for 4 clocks.
  - `busy` falls at N+41.
  - `fifo_count` reads 1 after N and 0 after N+1.
- **Back-to-back:** push 0x41, 0x42, 0x43 on consecutive edges.
  - Three frames, 120 clocks total at `DELAY_FRAMES`=4.
  - No high clock between stop bit and next start bit.
  - Decoded bytes arrive in order.
- **Full FIFO:** hold `in_valid` with the FSM busy until `fifo_count`=16.
  - `in_ready`=0 and pushes are ignored.
  - After the next pop, `in_ready`=1 one cycle later.
  - All 17 accepted bytes are eventually sent, in order.
- **Wrap-around:** stream 40 incrementing bytes 0x00–0x27 with a randomly toggled `in_valid`.
  - Received sequence exactly matches, covering pointer wrap at 16 and 32.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 5 bytes queued.
  - `uart_tx`=1 asynchronously, `fifo_count`=0, `busy`=0.
  - After release, push 0xA5: one clean frame of 0xA5 only.
- **Parity (`UART_TX_PARITY_EN`):**
  - Push 0x07: parity bit 1, frame 11·`DELAY_FRAMES` clocks.
  - Push 0x03: parity bit 0.
